// File: rtl/rv_pipe_pkg.sv
// Shared helpers for the elastic shift pipe: lane slicing and parameter sanity.
package rv_pipe_pkg;

    function automatic int laneLsb(input int lane, input int dataw);
        return lane * dataw;
    endfunction

    function automatic bit paramsOk(input int depth, input int dataw, input int resetw);
        return (depth >= 1) && (resetw >= 0) && (resetw <= dataw);
    endfunction

endpackage

// File: rtl/rv_pipe_stage.sv
// One register stage of the elastic pipe: a valid bit plus LANES data lanes,
// where only the top RESETW bits of each lane are cleared by reset.
module rv_pipe_stage
    import rv_pipe_pkg::*;
#(
    parameter int DATAW  = 8,
    parameter int LANES  = 1,
    parameter int RESETW = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ld,
    input  logic                   v_in,
    input  logic [LANES*DATAW-1:0] d_in,
    output logic                   v_out,
    output logic [LANES*DATAW-1:0] d_out
);

    logic r_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
        end else if (ld) begin
            r_valid <= v_in;
        end
    end

    assign v_out = r_valid;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam int LSB = laneLsb(k, DATAW);

        if (RESETW > 0) begin : g_rst
            logic [RESETW-1:0] r_hi;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_hi <= '0;
                end else if (ld) begin
                    r_hi <= d_in[LSB+DATAW-RESETW +: RESETW];
                end
            end

            assign d_out[LSB+DATAW-RESETW +: RESETW] = r_hi;
        end

        // Low bits carry no meaning while the stage is invalid, so they skip reset.
        if (RESETW < DATAW) begin : g_noRst
            logic [DATAW-RESETW-1:0] r_lo;

            always_ff @(posedge clk) begin
                if (ld) begin
                    r_lo <= d_in[LSB +: DATAW-RESETW];
                end
            end

            assign d_out[LSB +: DATAW-RESETW] = r_lo;
        end
    end

endmodule

// File: rtl/rv_elastic_shift_pipe.sv
// Elastic delay line: DEPTH valid/ready register stages with bubble collapsing,
// backpressure, a synchronous flush and a registered occupancy count.
module rv_elastic_shift_pipe
    import rv_pipe_pkg::*;
#(
    parameter int DATAW  = 8,
    parameter int LANES  = 1,
    parameter int RESETW = 0,
    parameter int DEPTH  = 2,
    parameter int CNTW   = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [LANES*DATAW-1:0] in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [LANES*DATAW-1:0] out_data,
    input  logic                   out_ready,
    output logic [CNTW-1:0]        count
);

    if (!paramsOk(DEPTH, DATAW, RESETW)) begin : g_badParams
        $error("rv_elastic_shift_pipe: need DEPTH >= 1 and 0 <= RESETW <= DATAW");
    end

    logic [DEPTH-1:0]       w_valid;
    logic [DEPTH-1:0]       w_adv;
    logic [LANES*DATAW-1:0] w_data [DEPTH];
    logic                   w_inFire;
    logic                   w_outFire;
    logic [CNTW-1:0]        r_count;

    // A stage may advance if anything at or ahead of it is empty, or the tail drains.
    always_comb begin
        w_adv = '0;
        w_adv[DEPTH-1] = out_ready | ~w_valid[DEPTH-1];
        for (int i = DEPTH - 2; i >= 0; i--) begin
            w_adv[i] = w_adv[i+1] | ~w_valid[i];
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic                   w_vIn;
        logic [LANES*DATAW-1:0] w_dIn;

        // Flush loads a zero valid bit but feeds each stage its own data back.
        if (i == 0) begin : g_head
            assign w_vIn = in_valid & ~flush;
            assign w_dIn = flush ? w_data[0] : in_data;
        end else begin : g_body
            assign w_vIn = w_valid[i-1] & ~flush;
            assign w_dIn = flush ? w_data[i] : w_data[i-1];
        end

        rv_pipe_stage #(
            .DATAW  (DATAW),
            .LANES  (LANES),
            .RESETW (RESETW)
        ) u_stage (
            .clk   (clk),
            .reset (reset),
            .ld    (w_adv[i] | flush),
            .v_in  (w_vIn),
            .d_in  (w_dIn),
            .v_out (w_valid[i]),
            .d_out (w_data[i])
        );
    end

    assign in_ready  = w_adv[0] & ~flush;
    assign out_valid = w_valid[DEPTH-1];
    assign out_data  = w_data[DEPTH-1];
    assign w_inFire  = in_valid & in_ready;
    assign w_outFire = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else if (w_inFire && !w_outFire) begin
            r_count <= r_count + CNTW'(1);
        end else if (w_outFire && !w_inFire) begin
            r_count <= r_count - CNTW'(1);
        end
    end

    assign count = r_count;

endmodule

// File: tb/tb_rv_elastic_shift_pipe.sv
// Self-checking bench for rv_elastic_shift_pipe: directed scenarios followed by
// random traffic, all compared against a slot-position reference model.
module tb_rv_elastic_shift_pipe;

    localparam int DATAW  = 8;
    localparam int LANES  = 2;
    localparam int RESETW = 4;
    localparam int DEPTH  = 3;
    localparam int CNTW   = $clog2(DEPTH + 1);
    localparam int W      = LANES * DATAW;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic            in_valid;
    logic [W-1:0]    in_data;
    logic            in_ready;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic            out_ready;
    logic [CNTW-1:0] count;

    int checks   = 0;
    int failures = 0;

    // Model: items oldest-first, each with the slot index it occupies (0 = entry).
    logic [W-1:0] modelData[$];
    int           modelPos[$];

    always #5 clk = ~clk;

    rv_elastic_shift_pipe #(
        .DATAW  (DATAW),
        .LANES  (LANES),
        .RESETW (RESETW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit modelOutValid();
        return (modelPos.size() > 0) && (modelPos[0] == DEPTH - 1);
    endfunction

    task automatic checkOutput(input string tag);
        bit expValid;
        bit expReady;
        expValid = modelOutValid();
        expReady = !flush && (out_ready || (modelData.size() < DEPTH));
        checkEq({tag, ".count"}, 32'(count), 32'(modelData.size()));
        checkEq({tag, ".out_valid"}, 32'(out_valid), 32'(expValid));
        checkEq({tag, ".in_ready"}, 32'(in_ready), 32'(expReady));
        if (expValid) begin
            checkEq({tag, ".out_data"}, 32'(out_data), 32'(modelData[0]));
        end
    endtask

    // Drive one cycle from posedge+1, check at negedge, then advance the model at the edge.
    task automatic applyStimulus(input logic inV, input logic [W-1:0] inD, input logic outR,
                                 input logic fl, input string tag);
        bit inFire;
        bit outFire;
        int n;
        in_valid  = inV;
        in_data   = inD;
        out_ready = outR;
        flush     = fl;
        @(negedge clk);
        checkOutput(tag);
        inFire  = inV && !fl && (outR || (modelData.size() < DEPTH));
        outFire = modelOutValid() && outR;
        @(posedge clk);
        if (fl) begin
            modelData.delete();
            modelPos.delete();
        end else begin
            n = modelPos.size();
            for (int k = 0; k < n; k++) begin
                if ((modelPos[k] < DEPTH - 1) && (((DEPTH - 1 - modelPos[k]) > k) || outR)) begin
                    modelPos[k] = modelPos[k] + 1;
                end
            end
            if (outFire) begin
                void'(modelData.pop_front());
                void'(modelPos.pop_front());
            end
            if (inFire) begin
                modelData.push_back(inD);
                modelPos.push_back(0);
            end
        end
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #2;
        checkOutput("reset");
        #8;
        reset = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] back-to-back throughput");
        applyStimulus(1'b1, 16'h5A11, 1'b1, 1'b0, "t1.push0");
        applyStimulus(1'b1, 16'h5A22, 1'b1, 1'b0, "t1.push1");
        applyStimulus(1'b1, 16'h5A33, 1'b1, 1'b0, "t1.push2");
        checkEq("t1.peak_count", 32'(count), 32'd3);
        checkEq("t1.first_out", 32'(out_data[7:0]), 32'h11);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, "t1.drain");

        $display("[TB] fill under backpressure then pass-through");
        applyStimulus(1'b1, 16'h00A1, 1'b0, 1'b0, "t2.fill0");
        applyStimulus(1'b1, 16'h00A2, 1'b0, 1'b0, "t2.fill1");
        applyStimulus(1'b1, 16'h00A3, 1'b0, 1'b0, "t2.fill2");
        checkEq("t2.full_count", 32'(count), 32'd3);
        checkEq("t2.full_in_ready", 32'(in_ready), 32'd0);
        checkEq("t2.held_data", 32'(out_data[7:0]), 32'hA1);
        applyStimulus(1'b1, 16'h00A4, 1'b1, 1'b0, "t2.passthru");
        checkEq("t2.count_kept", 32'(count), 32'd3);
        checkEq("t2.next_head", 32'(out_data[7:0]), 32'hA2);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, "t2.drain");

        $display("[TB] bubble collapse");
        applyStimulus(1'b1, 16'h0001, 1'b0, 1'b0, "t3.push0");
        applyStimulus(1'b0, '0,       1'b0, 1'b0, "t3.gap");
        applyStimulus(1'b1, 16'h0002, 1'b0, 1'b0, "t3.push1");
        applyStimulus(1'b0, '0,       1'b0, 1'b0, "t3.hold");
        checkEq("t3.count", 32'(count), 32'd2);
        checkEq("t3.out_valid", 32'(out_valid), 32'd1);
        checkEq("t3.head", 32'(out_data[7:0]), 32'h01);

        $display("[TB] flush with pending input");
        in_valid = 1'b1;
        flush    = 1'b1;
        #1;
        checkEq("t4.in_ready", 32'(in_ready), 32'd0);
        applyStimulus(1'b1, 16'h0099, 1'b0, 1'b1, "t4.flush");
        checkEq("t4.count", 32'(count), 32'd0);
        checkEq("t4.out_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, "t4.after");

        $display("[TB] asynchronous reset mid-stream");
        applyStimulus(1'b1, 16'hFFEE, 1'b0, 1'b0, "t5.fill0");
        applyStimulus(1'b1, 16'hF0F0, 1'b0, 1'b0, "t5.fill1");
        applyStimulus(1'b1, 16'hFFFF, 1'b0, 1'b0, "t5.fill2");
        in_valid = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        checkEq("t5.out_valid", 32'(out_valid), 32'd0);
        checkEq("t5.count", 32'(count), 32'd0);
        checkEq("t5.lane0_hi", 32'(out_data[7:4]), 32'd0);
        checkEq("t5.lane1_hi", 32'(out_data[15:12]), 32'd0);
        checkEq("t5.in_ready", 32'(in_ready), 32'd1);
        modelData.delete();
        modelPos.delete();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] random traffic");
        for (int i = 0; i < 10000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 63) == 0), "t6.rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
